// File: rtl/spi_result_tx_if.sv
// Bundles the SPI pins, the command strobe and the result/status signals
// of spi_result_tx.
//   slave  : the spi_result_tx side (samples pins and results, drives MISO and status)
//   master : the environment side (SPI master, receive shifter, network output stage)
//   SCK, SS, MISO       : SPI pins (SCK idle low, SS active low, MISO LSB first)
//   shift_SPI, SPI_in   : received command byte strobe and value
//   cost_ready, cost_output, network_done, detected_digit : finished result
//   fifo_count, fifo_full, overflow : result FIFO status
interface spi_result_tx_if #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned COST_W  = 8,
  parameter int unsigned DIGIT_W = 4,
  parameter int unsigned DEPTH   = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic               SCK;
  logic               SS;
  logic               MISO;
  logic               shift_SPI;
  logic [DATA_W-1:0]  SPI_in;
  logic               cost_ready;
  logic [COST_W-1:0]  cost_output;
  logic               network_done;
  logic [DIGIT_W-1:0] detected_digit;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               overflow;

  modport slave (
    input  SCK, SS, shift_SPI, SPI_in,
    input  cost_ready, cost_output, network_done, detected_digit,
    output MISO, fifo_count, fifo_full, overflow
  );

  modport master (
    output SCK, SS, shift_SPI, SPI_in,
    output cost_ready, cost_output, network_done, detected_digit,
    input  MISO, fifo_count, fifo_full, overflow
  );
endinterface

// File: rtl/spi_result_tx.sv
// SPI-slave transmit controller for the digit-recognizer result path.
// Finished results {cost, digit} are queued in a FIFO; command bytes select
// the head cost, head digit (optionally popping) or a status word, which is
// staged in tx_next and shifted out LSB first on MISO at the next word.
// Ports:
//   clk, n_rst : system clock, asynchronous active-low reset
//   bus        : spi_result_tx_if.slave (SPI pins, command strobe, results, status)
module spi_result_tx #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned COST_W  = 8,
  parameter int unsigned DIGIT_W = 4,
  parameter int unsigned DEPTH   = 4
) (
  input logic           clk,
  input logic           n_rst,
  spi_result_tx_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  // Counter only needs 0..DATA_W-1: the DATA_W-th fall reloads instead.
  localparam int unsigned BIT_W = $clog2(DATA_W);

  typedef struct packed {
    logic [COST_W-1:0]  cost;
    logic [DIGIT_W-1:0] digit;
  } entry_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // ---------------------------------------------------------------
  // Pin synchronisers and edge detection
  // ---------------------------------------------------------------
  logic [1:0] sck_sync, ss_sync;
  logic       sck_d, ss_d;
  logic       sck_fall_c, ss_fall_c, ss_high_c;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sck_sync <= 2'b00;
      sck_d    <= 1'b0;
      ss_sync  <= 2'b11;
      ss_d     <= 1'b1;
    end else begin
      sck_sync <= {sck_sync[0], bus.SCK};
      sck_d    <= sck_sync[1];
      ss_sync  <= {ss_sync[0], bus.SS};
      ss_d     <= ss_sync[1];
    end
  end

  assign sck_fall_c = sck_d & ~sck_sync[1];
  assign ss_fall_c  = ss_d  & ~ss_sync[1];
  assign ss_high_c  = ss_sync[1];

  // ---------------------------------------------------------------
  // Result FIFO state
  // ---------------------------------------------------------------
  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count_q, count_n;
  logic               full_q, full_n;
  logic               ovf_q, ovf_n;
  logic               empty_c;
  entry_t             head_c, new_entry_c;

  logic [7:0]         cmd_c;
  logic               spi_in_unused;
  logic               pop_c, push_c, drop_c, ovf_clr_c;
  logic [DATA_W-1:0]  status_c, tx_cmd_c;

  assign empty_c       = (count_q == '0);
  assign head_c        = mem[rd_ptr];
  assign cmd_c         = 8'(bus.SPI_in);
  assign spi_in_unused = ^bus.SPI_in;

  // Status snapshot taken before this cycle's push/pop
  always_comb begin
    status_c             = '0;
    status_c[CNT_W-1:0]  = count_q;
    status_c[DATA_W-2]   = empty_c;
    status_c[DATA_W-1]   = ovf_q;
  end

  // Command decode: value staged for tx_next, pop and overflow clear
  always_comb begin
    tx_cmd_c  = '1;
    pop_c     = 1'b0;
    ovf_clr_c = 1'b0;
    if (bus.shift_SPI) begin
      case (cmd_c)
        8'h01: if (!empty_c) tx_cmd_c = DATA_W'(head_c.cost);
        8'h02: if (!empty_c) tx_cmd_c = DATA_W'(head_c.digit);
        8'h03: begin
          if (!empty_c) begin
            tx_cmd_c = DATA_W'(head_c.digit);
            pop_c    = 1'b1;
          end
        end
        8'h04: begin
          tx_cmd_c  = status_c;
          ovf_clr_c = 1'b1;
        end
        default: tx_cmd_c = '1;
      endcase
    end
  end

  // Push accepted when there is room, including room freed by a same-cycle pop
  always_comb begin
    new_entry_c.cost  = bus.cost_ready ? bus.cost_output : '0;
    new_entry_c.digit = bus.detected_digit;
    push_c  = bus.network_done && ((count_q != CNT_W'(DEPTH)) || pop_c);
    drop_c  = bus.network_done && !push_c;
    count_n = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    full_n  = (count_n == CNT_W'(DEPTH));
    // A drop in the same cycle as a status read keeps the flag set
    ovf_n   = drop_c ? 1'b1 : (ovf_clr_c ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_n;
      full_q  <= full_n;
      ovf_q   <= ovf_n;
    end
  end

  // FIFO storage, not reset
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= new_entry_c;
  end

  // ---------------------------------------------------------------
  // Shifter FSM
  // ---------------------------------------------------------------
  state_t            state_q, state_n;
  logic [DATA_W-1:0] shreg_q, shreg_n;
  logic [DATA_W-1:0] tx_q, tx_n;
  logic [BIT_W-1:0]  bcnt_q, bcnt_n;
  logic              consume_c;
  logic              miso_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= ST_IDLE;
    else        state_q <= state_n;
  end

  // Next state, shift register, bit counter and tx_next update
  always_comb begin
    state_n   = state_q;
    shreg_n   = shreg_q;
    bcnt_n    = bcnt_q;
    consume_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bcnt_n = '0;
        if (ss_fall_c) begin
          shreg_n   = tx_q;
          consume_c = 1'b1;
          state_n   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ss_high_c) begin
          // Partial word is dropped; tx_next is left untouched
          bcnt_n  = '0;
          state_n = ST_IDLE;
        end else if (sck_fall_c) begin
          if (bcnt_q == BIT_W'(DATA_W - 1)) begin
            shreg_n   = tx_q;
            bcnt_n    = '0;
            consume_c = 1'b1;
          end else begin
            shreg_n = {1'b1, shreg_q[DATA_W-1:1]};
            bcnt_n  = bcnt_q + BIT_W'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // A command in the consuming cycle lands in tx_next for the next word
    tx_n = consume_c ? '1 : tx_q;
    if (bus.shift_SPI) tx_n = tx_cmd_c;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shreg_q <= '1;
      tx_q    <= '1;
      bcnt_q  <= '0;
      miso_q  <= 1'b1;
    end else begin
      shreg_q <= shreg_n;
      tx_q    <= tx_n;
      bcnt_q  <= bcnt_n;
      miso_q  <= (state_q == ST_SHIFT) ? shreg_q[0] : 1'b1;
    end
  end

  assign bus.MISO       = miso_q;
  assign bus.fifo_count = count_q;
  assign bus.fifo_full  = full_q;
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_spi_result_tx.sv
// Bench for spi_result_tx: an 8-bit/depth-4 instance and a 16-bit/cost-12/
// depth-8 instance share commands and results; each has its own SS so
// words are read from one instance at a time. Expected values come from a
// queue-based model of the result FIFO and the tx_next register.
module tb_spi_result_tx;

  logic clk;
  logic n_rst;
  logic sck, ss8, ss16, shift, done, crdy;
  logic [15:0] cmd16;
  logic [7:0]  cost8;
  logic [11:0] cost12;
  logic [3:0]  dig;

  int n_pass, n_fail, n_total;

  spi_result_tx_if #(.DATA_W(8),  .COST_W(8),  .DIGIT_W(4), .DEPTH(4)) b8 ();
  spi_result_tx_if #(.DATA_W(16), .COST_W(12), .DIGIT_W(4), .DEPTH(8)) b16 ();

  spi_result_tx #(.DATA_W(8), .COST_W(8), .DIGIT_W(4), .DEPTH(4)) dut8 (
    .clk(clk), .n_rst(n_rst), .bus(b8)
  );
  spi_result_tx #(.DATA_W(16), .COST_W(12), .DIGIT_W(4), .DEPTH(8)) dut16 (
    .clk(clk), .n_rst(n_rst), .bus(b16)
  );

  assign b8.SCK             = sck;
  assign b8.SS              = ss8;
  assign b8.shift_SPI       = shift;
  assign b8.SPI_in          = cmd16[7:0];
  assign b8.cost_ready      = crdy;
  assign b8.cost_output     = cost8;
  assign b8.network_done    = done;
  assign b8.detected_digit  = dig;
  assign b16.SCK            = sck;
  assign b16.SS             = ss16;
  assign b16.shift_SPI      = shift;
  assign b16.SPI_in         = cmd16;
  assign b16.cost_ready     = crdy;
  assign b16.cost_output    = cost12;
  assign b16.network_done   = done;
  assign b16.detected_digit = dig;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int q0[$];
  int q1[$];
  bit m_ovf[2];
  int m_tx[2];

  function automatic int dw(input int c);   return (c != 0) ? 16 : 8;          endfunction
  function automatic int dp(input int c);   return (c != 0) ? 8 : 4;           endfunction
  function automatic int ones(input int c); return (c != 0) ? 32'hFFFF : 32'hFF; endfunction
  function automatic int qsize(input int c); return (c != 0) ? q1.size() : q0.size(); endfunction
  function automatic int qhead(input int c); return (c != 0) ? q1[0] : q0[0];  endfunction

  function automatic void model_reset();
    q0.delete();
    q1.delete();
    for (int c = 0; c < 2; c++) begin
      m_ovf[c] = 1'b0;
      m_tx[c]  = ones(c);
    end
  endfunction

  function automatic void model_cmd(input int cmd);
    for (int c = 0; c < 2; c++) begin
      int sz;
      int v;
      sz = qsize(c);
      v  = ones(c);
      case (cmd & 255)
        1: if (sz > 0) v = qhead(c) >> 4;
        2: if (sz > 0) v = qhead(c) & 15;
        3: if (sz > 0) begin
             v = qhead(c) & 15;
             if (c != 0) void'(q1.pop_front()); else void'(q0.pop_front());
           end
        4: begin
             v = (int'(m_ovf[c]) << (dw(c) - 1)) | (int'(sz == 0) << (dw(c) - 2)) | sz;
             m_ovf[c] = 1'b0;
           end
        default: v = ones(c);
      endcase
      m_tx[c] = v;
    end
  endfunction

  function automatic void model_push(input bit cr, input int c8, input int c12, input int d);
    for (int c = 0; c < 2; c++) begin
      int cost;
      cost = cr ? ((c != 0) ? (c12 & 32'hFFF) : (c8 & 32'hFF)) : 0;
      if (qsize(c) == dp(c)) m_ovf[c] = 1'b1;
      else if (c != 0) q1.push_back(cost * 16 + (d & 15));
      else q0.push_back(cost * 16 + (d & 15));
    end
  endfunction

  function automatic int consume(input int c);
    int v;
    v = m_tx[c];
    m_tx[c] = ones(c);
    return v;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status();
    chk("count8",  32'(b8.fifo_count),  32'(q0.size()));
    chk("full8",   32'(b8.fifo_full),   32'(q0.size() == 4));
    chk("ovf8",    32'(b8.overflow),    32'(m_ovf[0]));
    chk("count16", 32'(b16.fifo_count), 32'(q1.size()));
    chk("full16",  32'(b16.fifo_full),  32'(q1.size() == 8));
    chk("ovf16",   32'(b16.overflow),   32'(m_ovf[1]));
  endtask

  // ---------------- stimulus helpers ----------------
  // One-cycle command and/or result pulse, then model update
  task automatic step(input bit do_cmd, input int cmd, input bit do_push,
                      input bit crv, input int c8, input int c12, input int d);
    @(posedge clk); #1;
    shift  = do_cmd;
    cmd16  = {8'($urandom), 8'(cmd)};
    done   = do_push;
    crdy   = crv;
    cost8  = 8'(c8);
    cost12 = 12'(c12);
    dig    = 4'(d);
    @(posedge clk); #1;
    shift  = 1'b0;
    done   = 1'b0;
    cost8  = 8'($urandom);
    cost12 = 12'($urandom);
    if (do_cmd)  model_cmd(cmd);
    if (do_push) model_push(crv, c8, c12, d);
  endtask

  task automatic set_ss(input int c, input logic v);
    if (c != 0) ss16 = v; else ss8 = v;
  endtask

  // One SCK period; MISO sampled just before the rising edge
  task automatic sck_bit(input int c, output logic b);
    repeat (7) @(posedge clk);
    @(negedge clk);
    b = (c != 0) ? b16.MISO : b8.MISO;
    @(posedge clk); #1 sck = 1'b1;
    repeat (8) @(posedge clk);
    #1 sck = 1'b0;
  endtask

  // Reads nw back-to-back words; optional command after bit 3 of word 0
  task automatic spi_read(input int c, input int nw, input int mid_cmd);
    int exp;
    logic [15:0] got;
    logic b;
    @(posedge clk); #1;
    set_ss(c, 1'b0);
    exp = consume(c);
    for (int w = 0; w < nw; w++) begin
      got = '0;
      for (int i = 0; i < dw(c); i++) begin
        sck_bit(c, b);
        got[i] = b;
        if (w == 0 && i == 3 && mid_cmd >= 0) step(1'b1, mid_cmd, 1'b0, 1'b0, 0, 0, 0);
      end
      chk((c != 0) ? "word16" : "word8", 32'(got), exp);
      // The final SCK fall of each word reloads from tx_next
      exp = consume(c);
    end
    repeat (4) @(posedge clk); #1;
    set_ss(c, 1'b1);
    repeat (6) @(posedge clk);
  endtask

  // Shifts 3 bits of a word and then deselects
  task automatic spi_abort(input int c);
    int exp;
    logic b;
    @(posedge clk); #1;
    set_ss(c, 1'b0);
    exp = consume(c);
    for (int i = 0; i < 3; i++) begin
      sck_bit(c, b);
      chk("abort_bit", 32'(b), (exp >> i) & 1);
    end
    repeat (4) @(posedge clk); #1;
    set_ss(c, 1'b1);
    repeat (6) @(posedge clk);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int r, c, cm;
    n_pass = 0; n_fail = 0; n_total = 0;
    n_rst = 1'b0;
    sck = 1'b0; ss8 = 1'b1; ss16 = 1'b1;
    shift = 1'b0; done = 1'b0; crdy = 1'b0;
    cmd16 = '0; cost8 = '0; cost12 = '0; dig = '0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_miso8",  32'(b8.MISO),  32'd1);
    chk("rst_miso16", 32'(b16.MISO), 32'd1);
    check_status();
    @(posedge clk); #1 n_rst = 1'b1;
    repeat (3) @(posedge clk);

    // Idle word with no command
    spi_read(0, 1, -1);
    spi_read(1, 1, -1);

    // Cost 133 / 0xABC, digit 7: head cost, then digit with pop
    step(1'b0, 0, 1'b1, 1'b1, 133, 12'hABC, 7);
    check_status();
    step(1'b1, 1, 1'b0, 1'b0, 0, 0, 0);
    spi_read(0, 1, -1);
    spi_read(1, 1, -1);
    step(1'b1, 3, 1'b0, 1'b0, 0, 0, 0);
    check_status();
    spi_read(0, 1, -1);
    spi_read(0, 1, -1);

    // Overfill the 4-deep instance, read status, drain in order
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 0, 1'b1, 1'b1, 10 + i, 100 + i, i + 1);
      check_status();
    end
    step(1'b1, 4, 1'b0, 1'b0, 0, 0, 0);
    check_status();
    spi_read(0, 1, -1);
    spi_read(1, 1, -1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 3, 1'b0, 1'b0, 0, 0, 0);
      check_status();
      spi_read(0, 1, -1);
    end
    step(1'b1, 2, 1'b0, 1'b0, 0, 0, 0);
    spi_read(0, 1, -1);

    // Same-cycle pop and push with two entries
    step(1'b0, 0, 1'b1, 1'b0, 1, 1, 9);
    step(1'b0, 0, 1'b1, 1'b1, 55, 555, 3);
    step(1'b1, 3, 1'b1, 1'b1, 66, 666, 12);
    check_status();
    spi_read(0, 1, -1);

    // Abort after 3 bits: restart sends current tx_next from bit 0
    step(1'b1, 1, 1'b0, 1'b0, 0, 0, 0);
    spi_abort(0);
    spi_read(0, 1, -1);
    step(1'b1, 2, 1'b0, 1'b0, 0, 0, 0);
    spi_read(0, 1, -1);

    // Command during a word only affects the following word
    step(1'b1, 1, 1'b0, 1'b0, 0, 0, 0);
    spi_read(0, 2, 2);
    spi_read(1, 1, -1);

    // Fill, then drop plus status clear in one cycle, then push on full with pop
    while (q0.size() < 4) step(1'b0, 0, 1'b1, 1'b1, $urandom, $urandom, $urandom_range(0, 15));
    check_status();
    step(1'b1, 4, 1'b1, 1'b1, 77, 777, 5);
    check_status();
    spi_read(0, 1, -1);
    step(1'b1, 3, 1'b1, 1'b1, 88, 888, 6);
    check_status();
    spi_read(0, 1, -1);

    // Randomized mix
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      c = $urandom_range(0, 1);
      cm = $urandom_range(1, 4);
      case (r)
        0, 1, 2, 3: step(1'b0, 0, 1'b1, $urandom_range(0, 3) != 0,
                         $urandom, $urandom, $urandom_range(0, 15));
        4, 5: step(1'b1, cm, 1'b0, 1'b0, 0, 0, 0);
        6: step(1'b1, cm, 1'b1, $urandom_range(0, 3) != 0,
                $urandom, $urandom, $urandom_range(0, 15));
        7: step(1'b1, ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(5, 255),
                1'b0, 1'b0, 0, 0, 0);
        default: step(1'b1, 3, 1'b0, 1'b0, 0, 0, 0);
      endcase
      check_status();
      if (r >= 4) spi_read(c, 1, -1);
    end

    // Reset mid-operation clears everything at once
    step(1'b0, 0, 1'b1, 1'b1, 1, 2, 3);
    step(1'b1, 1, 1'b0, 1'b0, 0, 0, 0);
    @(posedge clk); #3 n_rst = 1'b0;
    #1;
    model_reset();
    chk("midrst_miso8", 32'(b8.MISO), 32'd1);
    check_status();
    @(posedge clk); #1 n_rst = 1'b1;
    repeat (3) @(posedge clk);
    spi_read(0, 1, -1);
    spi_read(1, 1, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
